// File: rtl/if_id_buf_pkg.sv
// Shared definitions for the IF/ID instruction buffer: code window, control-transfer
// encodings, exception codes and the buffered entry layout.
package if_id_buf_pkg;

   // Code segment: `origin and `code_addr (segment size) give the legal fetch window.
   localparam logic [31:0] ORIGIN      = 32'h0000_3000;
   localparam logic [31:0] CODE_ADDR   = 32'h0000_4000;
   localparam logic [31:0] CODE_LO_DEF = ORIGIN;
   localparam logic [31:0] CODE_HI_DEF = ORIGIN + CODE_ADDR - 32'd4;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        bd;
      logic [4:0]  exc;
   } entry_t;

endpackage

// File: rtl/if_id_buf_ctl_xfer_dec.sv
// Combinational control-transfer detector (branches, jumps, jr/jalr); shared with
// the ID-stage hazard unit.
module ctl_xfer_dec
   import if_id_buf_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic       is_xfer
);

   always_comb begin
      is_xfer = 1'b0;
      case (op)
         OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_xfer = 1'b1;
         OP_SPECIAL: is_xfer = (funct == FN_JR) || (funct == FN_JALR);
         default:    is_xfer = 1'b0;
      endcase
   end

endmodule

// File: rtl/if_id_buf.sv
// IF/ID instruction buffer: DEPTH-entry FIFO between fetch and decode that tags each
// entry with its delay-slot flag and fetch-address exception.
module if_id_buf
   import if_id_buf_pkg::*;
#(
   parameter int          DEPTH   = 2,
   parameter logic [31:0] CODE_LO = CODE_LO_DEF,
   parameter logic [31:0] CODE_HI = CODE_HI_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        f_valid,
   input  logic [31:0] f_pc,
   input  logic [31:0] f_instr,
   output logic        f_ready,
   input  logic        flush,
   input  logic        d_ready,
   output logic        d_valid,
   output logic [31:0] d_pc,
   output logic [31:0] d_instr,
   output logic        d_bd,
   output logic [4:0]  d_exc
);

   localparam int           AW   = $clog2(DEPTH);
   localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

   entry_t          mem [DEPTH];
   entry_t          wr_ent;
   entry_t          head;
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [AW:0]     count;
   logic            last_jmp;
   logic            clr;
   logic            enq;
   logic            deq;
   logic            adel;
   logic            is_xfer;

   // Ready/valid depend only on registered count, so d_ready never reaches f_ready.
   assign f_ready = (count < FULL);
   assign d_valid = (count != '0);
   assign clr     = rst || flush;
   assign enq     = f_valid && f_ready && !clr;
   assign deq     = d_valid && d_ready && !clr;

   ctl_xfer_dec u_dec (
      .op      (f_instr[31:26]),
      .funct   (f_instr[5:0]),
      .is_xfer (is_xfer)
   );

   // A faulting fetch keeps its PC for EPC but becomes a nop.
   always_comb begin
      adel         = (f_pc[1:0] != 2'b00) || (f_pc < CODE_LO) || (f_pc > CODE_HI);
      wr_ent.pc    = f_pc;
      wr_ent.instr = adel ? 32'h0 : f_instr;
      wr_ent.bd    = last_jmp;
      wr_ent.exc   = adel ? EXC_ADEL : EXC_NONE;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         last_jmp <= 1'b0;
      end else begin
         if (enq) begin
            wptr     <= wptr + 1'b1;
            last_jmp <= is_xfer && !adel;
         end
         if (deq)
            rptr <= rptr + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq)
         mem[wptr] <= wr_ent;
   end

   assign head    = mem[rptr];
   assign d_pc    = d_valid ? head.pc    : 32'h0;
   assign d_instr = d_valid ? head.instr : 32'h0;
   assign d_bd    = d_valid ? head.bd    : 1'b0;
   assign d_exc   = d_valid ? head.exc   : EXC_NONE;

endmodule

// File: doc/if_id_buf.md
# if_id_buf

Instruction buffer and IF/ID boundary for the 5-stage MIPS pipeline. It sits directly downstream of the instruction fetch unit and holds up to DEPTH fetched instructions in a FIFO, so a decode stall back-pressures fetch through `f_ready`, which drives the fetch enable. For each entry it also records the branch-delay-slot flag and the fetch-address exception code, which the exception/CP0 logic needs.

## Interface
Parameters:
- DEPTH, 2: FIFO entries; power of two, ≥2.
- CODE_LO, 32'h0000_3000: lowest legal fetch address.
- CODE_HI, 32'h0000_6ffc: highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- f_valid  in  1  fetch presents a new instruction this cycle.
- f_pc  in  32  PC of the presented instruction.
- f_instr  in  32  presented instruction word.
- f_ready  out  1  buffer accepts; drives the fetch-unit enable.
- flush  in  1  discard all buffered state (exception entry or eret).
- d_ready  in  1  decode consumes the head entry this cycle.
- d_valid  out  1  head entry is valid.
- d_pc  out  32  head PC.
- d_instr  out  32  head instruction; forced to 0 (nop) on exception.
- d_bd  out  1  head is in a branch delay slot.
- d_exc  out  5  head exception code: 0 = none, 4 = AdEL.

## Operation
- Enqueue when `f_valid && f_ready && !flush`. Dequeue when `d_valid && d_ready && !flush`.
- `f_ready = (count < DEPTH)`. It is a function of registered state only, so there is no combinational path from `d_ready`. When the buffer is full, a same-cycle dequeue does not open a slot until the next cycle.
- Enqueue and dequeue may happen in the same cycle. In that case `count` is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits wide.
- Exception check at enqueue: set AdEL (5'd4) if `f_pc[1:0] != 0`, or if `f_pc < CODE_LO`, or if `f_pc > CODE_HI`. The entry then stores `instr = 0` and `exc = 4`; `f_pc` is kept unchanged so the EPC is correct.
- Delay-slot tracking: register `last_jmp` is updated on every enqueue. It is set to 1 when the enqueued word is a control transfer, otherwise 0. The entry's `bd` bit is the value of `last_jmp` before the update.
- Control transfers are:
  - opcode 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06 or 6'h07;
  - opcode 6'h00 with funct 6'h08 (jr) or 6'h09 (jalr).
- A faulting entry (`exc != 0`) always sets `last_jmp` to 0.
- Flush clears `count`, both pointers and `last_jmp`. It overrides any enqueue or dequeue in the same cycle.
- Head outputs come from the entry at the read pointer. While `d_valid = 0`, the outputs `d_pc`, `d_instr`, `d_bd` and `d_exc` are all driven to 0.

## Timing
- Reset, registered at the clock edge: `count = 0`, pointers = 0, `last_jmp = 0`. Immediately after reset: `d_valid = 0`, all `d_*` = 0, `f_ready = 1`.
- Reset asserted mid-operation behaves exactly like flush, plus the reset values above. Buffered entries are lost.
- Latency: an instruction enqueued at edge N appears on the `d_*` outputs during the cycle after edge N. There is no combinational bypass when the buffer is empty.
- Throughput: one instruction per cycle sustained with `d_ready = 1`.
- A flush in cycle N gives `d_valid = 0` and `f_ready = 1` in cycle N+1.
- The entry presented by fetch in the flush cycle is dropped. The redirected fetch PC is the next one accepted.
- The head entry is stable while `d_valid && !d_ready`.

## Structure
- The def.v header holds the shared definitions:
  - `` `origin `` and `` `code_addr ``, from which CODE_LO and CODE_HI are derived;
  - the control-transfer opcode and funct constants;
  - the exception code `` `EXC_ADEL = 5'd4 ``.
- One natural sub-module: `ctl_xfer_dec`, a combinational detector returning 1 for control-transfer instructions. The ID-stage hazard unit reuses it.
- Entry storage is an array of {pc, instr, bd, exc} registers, 70 bits per entry.

## Test plan
- Reset, then `f_valid = 1` with pc 0x3000, 0x3004, 0x3008 and `d_ready = 1` → `d_pc` shows 0x3000 and 0x3004 on consecutive cycles starting one cycle after the first accept, with `d_bd = 0` and `d_exc = 0`.
- Hold `d_ready = 0` and push 3 words → `f_ready` drops after 2 accepts. The third word is held at fetch. Raising `d_ready` releases all three in order with no loss or duplicate.
- Push beq (0x1000_0003) at 0x3000, then the word at 0x3004 → the 0x3004 entry has `d_bd = 1` and the next entry has `d_bd = 0`. Repeat with jr (0x03e0_0008).
- Push pc 0x3002, then pc 0x7000 → both entries show `d_exc = 4`, `d_instr = 0` and the pc unchanged. A following 0x3000 entry has `d_exc = 0`.
- Fill the buffer, then assert flush together with `f_valid` and `d_ready` → in the next cycle `d_valid = 0` and `f_ready = 1`. A post-flush push at 0x4180 after a pre-flush branch has `d_bd = 0`.
- Assert rst for one cycle with 2 entries buffered → the next cycle shows `d_valid = 0` and all `d_*` = 0.
